// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data memory stage.
// Size codes, controller state enum, and byte-lane steering/extension functions.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  lo;
    logic [31:0] wdata;
  } req_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lo[0];
      default:   return lo != 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: return lo;
      SIZE_HALF: return {lo[1], 1'b0};
      default:   return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: return 4'b0001 << lo;
      SIZE_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

  // Replicating the narrow store data onto every lane lets byte enables pick the lane.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SIZE_BYTE: return {4{wdata[7:0]}};
      SIZE_HALF: return {2{wdata[15:0]}};
      default:   return wdata;
    endcase
  endfunction

  function automatic logic [31:0] extract_extend(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lo, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: return {{24{b[7] & ~uns}}, b};
      SIZE_HALF: return {{16{h[15] & ~uns}}, h};
      default:   return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data RAM with per-byte write enables and a registered read port.
module dmem_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  // NOTE: the array has no reset branch so it maps onto block RAM; contents survive rst.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Multi-cycle data memory controller: IDLE/WAIT/DONE FSM, lane steering, load extension.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_req,
  input  logic        in_we,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic [31:0] out_rdata,
  output logic        out_ready,
  output logic        out_busy,
  output logic        out_misaligned
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  req_t                  req_q, cur;
  logic [ADDR_WIDTH-1:0] idx_q, cur_idx;
  logic [31:0]           rdata_q, ram_rdata, ram_wdata, load_val;
  logic                  ready_q, go_done, trap;
  logic [1:0]            lane;
  logic [3:0]            ram_be;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^in_addr[31:ADDR_WIDTH+2];

  // In IDLE the access comes straight from the inputs so a zero-wait access can
  // commit on its accept edge; afterwards it comes from the latched copy.
  // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latch).
  always_comb begin
    cur     = req_q;
    cur_idx = idx_q;
    if (state_q == S_IDLE) begin
      cur     = '{we: in_we, size: in_size, uns: in_unsigned, lo: in_addr[1:0], wdata: in_wdata};
      cur_idx = in_addr[ADDR_WIDTH+1:2];
    end
  end

  assign lane = align_lo(cur.size, cur.lo);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = is_misaligned(cur.size, cur.lo);
`else
  assign trap = 1'b0;
`endif

  assign go_done = ((state_q == S_IDLE) && in_req && (WAIT_CYCLES == 0)) ||
                   ((state_q == S_WAIT) && (cnt_q == '0));

  assign ram_be    = (go_done && cur.we && !trap && !in_rst) ? byte_en(cur.size, lane) : 4'b0000;
  assign ram_wdata = lane_data(cur.size, cur.wdata);

  dmem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk_i   (in_clk),
    .addr_i  (cur_idx),
    .be_i    (ram_be),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign load_val = trap ? 32'h0 : extract_extend(ram_rdata, cur.size, lane, cur.uns);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= go_done;
      case (state_q)
        S_IDLE: begin
          if (in_req) begin
            req_q   <= cur;
            idx_q   <= cur_idx;
            cnt_q   <= CNT_LOAD;
            state_q <= go_done ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) state_q <= S_DONE;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        S_DONE: begin
          if (!req_q.we) rdata_q <= load_val;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misaligned_q;
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) misaligned_q <= 1'b0;
    else        misaligned_q <= go_done && trap;
  end
  assign out_misaligned = misaligned_q;
`else
  assign out_misaligned = 1'b0;
`endif

  // The RAM read lands in DONE; present it immediately, then hold it in rdata_q.
  assign out_rdata = ((state_q == S_DONE) && !req_q.we) ? load_val : rdata_q;
  assign out_ready = ready_q;
  assign out_busy  = !in_rst && (((state_q == S_IDLE) && in_req) || (state_q == S_WAIT));

endmodule
